pcpi_issuer: RTL
================

# pcpi_issuer

CPU-side initiator for the PCPI co-processor interface. It accepts one instruction and its two operands over a ready/valid request port and drives `pcpi_valid`, `pcpi_insn`, `pcpi_rs1` and `pcpi_rs2` toward the M-extension unit. It holds them until the unit reports `pcpi_ready`, or until a no-claim timeout expires, then returns the result over a ready/valid response port. It sits between the core's execute stage (or a bus-driven test harness) and `m_controller`'s datapath wrapper.

## Interface
- `TIMEOUT`, default 16: number of cycles `pcpi_valid` may stay high with neither `pcpi_busy` nor `pcpi_ready` seen before the request is abandoned; legal range is at least 2.
- `clk` in 1: clock; all logic is on the rising edge.
- `resetn` in 1: reset, asynchronous and active-low.
- `req_valid` in 1: a request is offered.
- `req_ready` out 1: the block can accept a request; high only in IDLE.
- `req_insn` in 32: instruction word.
- `req_rs1` in 32: first operand.
- `req_rs2` in 32: second operand.
- `pcpi_valid` out 1: request to the co-processor.
- `pcpi_insn` out 32: registered instruction.
- `pcpi_rs1` out 32: registered first operand.
- `pcpi_rs2` out 32: registered second operand.
- `pcpi_busy` in 1: the co-processor has claimed the instruction.
- `pcpi_ready` in 1: the co-processor result is valid this cycle.
- `pcpi_wr` in 1: the co-processor writes `rd`.
- `pcpi_rd` in 32: co-processor result.
- `resp_valid` out 1: a response is held.
- `resp_ready` in 1: the consumer accepts the response.
- `resp_data` out 32: captured result.
- `resp_wr` out 1: captured `pcpi_wr`.
- `resp_err` out 1: no co-processor claimed the instruction (illegal-instruction indication).

## Operation
- States are IDLE, ISSUE and RESP.
- Reset values: state IDLE; `req_ready` 1; `pcpi_valid` 0; `pcpi_insn`, `pcpi_rs1`, `pcpi_rs2` 0; `resp_valid` 0; `resp_data` 0; `resp_wr` 0; `resp_err` 0; timeout counter 0.
- **IDLE:**
  - On `req_valid && req_ready`, register insn, rs1 and rs2, set `pcpi_valid`, clear the counter, and go to ISSUE.
- **ISSUE:**
  - `pcpi_insn`, `pcpi_rs1` and `pcpi_rs2` are stable for the whole state. The unit re-reads rs1 and rs2 in its final cycle for sign correction, so they must not change.
  - If `pcpi_ready`: capture `resp_data = pcpi_wr ? pcpi_rd : 0` and `resp_wr = pcpi_wr`, set `resp_err = 0`, clear `pcpi_valid`, and go to RESP.
  - Else if `pcpi_busy`: clear the counter.
  - Else if the counter equals `TIMEOUT-1`: clear `pcpi_valid`, set `resp_data = 0`, `resp_wr = 0`, `resp_err = 1`, and go to RESP.
  - Else increment the counter.
  - `pcpi_ready` takes priority over an expiring timeout in the same cycle.
- **RESP:**
  - `resp_valid = 1`; the response fields are held stable.
  - On `resp_ready`, go to IDLE with `resp_valid` deasserted by the registered update.
- `pcpi_ready`, `pcpi_busy`, `pcpi_wr` and `pcpi_rd` are ignored outside ISSUE.
- `pcpi_valid` is always low for at least one full cycle between transactions, because RESP lasts at least one cycle. This guarantees the responder sees `pcpi_valid` low in its IDLE state after DONE and does not re-launch.
- Reset mid-transaction returns the block to IDLE immediately. `pcpi_valid` drops asynchronously and any pending response is discarded.

## Timing
- Request acceptance edge = cycle 0. `pcpi_valid` is high from cycle 1.
- With `m_controller`:
  - MUL family: `pcpi_ready` in cycle 4, `resp_valid` from cycle 5.
  - DIV/REM family: `pcpi_ready` in cycle 36, `resp_valid` from cycle 37.
- Unclaimed instruction: `pcpi_valid` is high for cycles 1..TIMEOUT, and `resp_valid` with `resp_err` is high from cycle TIMEOUT+1.
- `pcpi_valid` is deasserted starting the cycle after `pcpi_ready` is sampled.
- Throughput is one transaction per (co-processor latency + 2) cycles when `resp_ready` is held high.
- `req_ready` is combinationally equal to (state == IDLE). There is no combinational path from `req_*` to `pcpi_*`, or from `pcpi_*` to `resp_*`.

## Structure
- `m_pkg` (shared) holds the OPCODE and FUNC7 constants, the func3 enum (MUL..REMU), and the `get_ir_*` helpers. The bench uses these to build instructions.
- The state enum `pcpi_issuer_state_t` is local to the module.
- The counter width is `$clog2(TIMEOUT)`.
- No sub-module; the block is a single always_ff plus an always_comb.

## Test plan
- MUL: rs1=7, rs2=6 with `m_controller` attached → `resp_valid` at cycle 5, `resp_data` = 42, `resp_wr` = 1, `resp_err` = 0.
- DIV: rs1=-20 (0xFFFFFFEC), rs2=3 → `resp_valid` at cycle 37, `resp_data` = 0xFFFFFFFA (-6). `pcpi_rs1` and `pcpi_rs2` are unchanged throughout ISSUE.
- Non-M instruction 0x00000013 (ADDI), TIMEOUT=16 → `pcpi_valid` high for exactly 16 cycles, then `resp_err` = 1, `resp_data` = 0.
- Backpressure: hold `resp_ready` = 0 for 10 cycles after a MULHU of 0xFFFFFFFF×2 → `resp_data` = 1 is held stable, `req_ready` = 0 throughout, and `pcpi_valid` = 0.
- Back-to-back REM(-7,2) then MUL(3,3) with `req_valid` held high → responses -1 then 9, and `pcpi_valid` is low for at least 1 cycle between the two.
- Reset asserted at cycle 10 of a DIV → all outputs at reset values in the same cycle; the next request completes normally.

Source files
------------

// File: rtl/m_pkg.sv
// M-extension encodings and instruction-field helpers.
// Shared by the PCPI issuer, the M unit and their benches.
package m_pkg;

    localparam logic [6:0] OPCODE = 7'b0110011;
    localparam logic [6:0] FUNC7  = 7'b0000001;

    typedef enum logic [2:0] {
        MUL, MULH, MULHSU, MULHU,
        DIV, DIVU, REM, REMU
    } func3_t;

    function automatic logic [6:0] get_ir_opcode(input logic [31:0] ir);
        return ir[6:0];
    endfunction

    function automatic logic [4:0] get_ir_rd(input logic [31:0] ir);
        return ir[11:7];
    endfunction

    function automatic func3_t get_ir_func3(input logic [31:0] ir);
        return func3_t'(ir[14:12]);
    endfunction

    function automatic logic [4:0] get_ir_rs1(input logic [31:0] ir);
        return ir[19:15];
    endfunction

    function automatic logic [4:0] get_ir_rs2(input logic [31:0] ir);
        return ir[24:20];
    endfunction

    function automatic logic [6:0] get_ir_func7(input logic [31:0] ir);
        return ir[31:25];
    endfunction

    function automatic logic is_m_ir(input logic [31:0] ir);
        return get_ir_opcode(ir) == OPCODE && get_ir_func7(ir) == FUNC7;
    endfunction

    function automatic logic [31:0] build_m_ir(
        input func3_t     f3,
        input logic [4:0] rd,
        input logic [4:0] rs1,
        input logic [4:0] rs2
    );
        return {FUNC7, rs2, rs1, f3, rd, OPCODE};
    endfunction

endpackage

// File: rtl/pcpi_issuer.sv
// PCPI initiator: holds one instruction on the co-processor port
// until it is answered or times out unclaimed, then returns the result.
module pcpi_issuer #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_insn,
    input  logic [31:0] req_rs1,
    input  logic [31:0] req_rs2,
    output logic        pcpi_valid,
    output logic [31:0] pcpi_insn,
    output logic [31:0] pcpi_rs1,
    output logic [31:0] pcpi_rs2,
    input  logic        pcpi_busy,
    input  logic        pcpi_ready,
    input  logic        pcpi_wr,
    input  logic [31:0] pcpi_rd,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_data,
    output logic        resp_wr,
    output logic        resp_err
);

    localparam int CW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        RESP
    } pcpi_issuer_state_t;

    pcpi_issuer_state_t state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               pv_d;
    logic [31:0]        insn_d, rs1_d, rs2_d;
    logic [31:0]        data_d;
    logic               wr_d, err_d;

    assign req_ready  = (state_q == IDLE);
    assign resp_valid = (state_q == RESP);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pv_d    = pcpi_valid;
        insn_d  = pcpi_insn;
        rs1_d   = pcpi_rs1;
        rs2_d   = pcpi_rs2;
        data_d  = resp_data;
        wr_d    = resp_wr;
        err_d   = resp_err;
        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    state_d = ISSUE;
                    pv_d    = 1'b1;
                    insn_d  = req_insn;
                    rs1_d   = req_rs1;
                    rs2_d   = req_rs2;
                    cnt_d   = '0;
                end
            end
            ISSUE: begin
                // ready wins over a timeout expiring in the same cycle
                if (pcpi_ready) begin
                    state_d = RESP;
                    pv_d    = 1'b0;
                    data_d  = pcpi_wr ? pcpi_rd : 32'h0;
                    wr_d    = pcpi_wr;
                    err_d   = 1'b0;
                end else if (pcpi_busy) begin
                    cnt_d = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = RESP;
                    pv_d    = 1'b0;
                    data_d  = 32'h0;
                    wr_d    = 1'b0;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            RESP: begin
                if (resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            pcpi_valid <= 1'b0;
            pcpi_insn  <= 32'h0;
            pcpi_rs1   <= 32'h0;
            pcpi_rs2   <= 32'h0;
            resp_data  <= 32'h0;
            resp_wr    <= 1'b0;
            resp_err   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            pcpi_valid <= pv_d;
            pcpi_insn  <= insn_d;
            pcpi_rs1   <= rs1_d;
            pcpi_rs2   <= rs2_d;
            resp_data  <= data_d;
            resp_wr    <= wr_d;
            resp_err   <= err_d;
        end
    end

endmodule
